// File: rtl/instr_decode_stage.sv
// RV32I ALU-instruction decode stage: decodes OP/OP-IMM, strobes the register file,
// waits one cycle in S1 for read data, then presents a held operation to the ALU.
module instr_decode_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      arst_ni,
  input  logic                      flush_i,
  input  logic [31:0]               instr_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr_o,
  output logic                      rf_rd_en_o,
  input  logic [DATA_WIDTH-1:0]     rf_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rf_rs2_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [3:0]                op_o,
  output logic                      use_imm_o,
  output logic [DATA_WIDTH-1:0]     rs1_data_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  logic                      dec_illegal;
  logic [3:0]                dec_op;
  logic                      dec_use_imm;
  logic [DATA_WIDTH-1:0]     dec_imm;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;

  // Illegal encodings leave every decoded field at zero so they flow through harmlessly.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dec_illegal = 1'b1;
    dec_op      = 4'b0000;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    dec_rd      = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ZERO ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_illegal = 1'b0;
          dec_op      = {funct7[5], funct3};
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_ZERO) begin
              dec_illegal = 1'b0;
              dec_op      = {1'b0, funct3};
              dec_use_imm = 1'b1;
              dec_imm     = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
            end
          end
          3'b101: begin
            if (funct7 == F7_ZERO || funct7 == F7_ALT) begin
              dec_illegal = 1'b0;
              dec_op      = {instr_i[30], funct3};
              dec_use_imm = 1'b1;
              dec_imm     = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
            end
          end
          default: begin
            dec_illegal = 1'b0;
            dec_op      = {1'b0, funct3};
            dec_use_imm = 1'b1;
            dec_imm     = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
          end
        endcase
      end
      default: ;
    endcase
    if (!dec_illegal) begin
      dec_rd = REG_ADDR_WIDTH'(instr_i[11:7]);
    end
  end

  logic                      s1_valid;
  logic                      s1_illegal;
  logic [3:0]                s1_op;
  logic                      s1_use_imm;
  logic [DATA_WIDTH-1:0]     s1_imm;
  logic [REG_ADDR_WIDTH-1:0] s1_rd;
  logic                      accept;

  // S1 always drains into OUT on the next edge, so accepting only when OUT is free or leaving is enough.
  assign instr_ready_o = arst_ni && !flush_i && !s1_valid && (!ex_valid_o || ex_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;
  assign rf_rd_en_o    = accept;
  assign rf_rs1_addr_o = REG_ADDR_WIDTH'(instr_i[19:15]);
  assign rf_rs2_addr_o = REG_ADDR_WIDTH'(instr_i[24:20]);

  always_ff @(posedge clk or negedge arst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!arst_ni) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      s1_op      <= 4'b0000;
      s1_use_imm <= 1'b0;
      s1_imm     <= '0;
      s1_rd      <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_illegal <= dec_illegal;
        s1_op      <= dec_op;
        s1_use_imm <= dec_use_imm;
        s1_imm     <= dec_imm;
        s1_rd      <= dec_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      ex_valid_o <= 1'b0;
      op_o       <= 4'b0000;
      use_imm_o  <= 1'b0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      rd_addr_o  <= '0;
      illegal_o  <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (s1_valid) begin
      ex_valid_o <= 1'b1;
      op_o       <= s1_op;
      use_imm_o  <= s1_use_imm;
      rd_addr_o  <= s1_rd;
      illegal_o  <= s1_illegal;
      rs1_data_o <= s1_illegal ? '0 : rf_rs1_data_i;
      rs2_data_o <= s1_illegal ? '0 : (s1_use_imm ? s1_imm : rf_rs2_data_i);
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed vector table, multi-cycle
// corner sequences, then random traffic against a queue-based reference model.
module tb_instr_decode_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic          clk = 1'b0;
  logic          arst_ni;
  logic          flush_i;
  logic [31:0]   instr_i;
  logic          instr_valid_i;
  logic          instr_ready_o;
  logic [AW-1:0] rf_rs1_addr_o;
  logic [AW-1:0] rf_rs2_addr_o;
  logic          rf_rd_en_o;
  logic [DW-1:0] rf_rs1_data_i;
  logic [DW-1:0] rf_rs2_data_i;
  logic          ex_valid_o;
  logic          ex_ready_i;
  logic [3:0]    op_o;
  logic          use_imm_o;
  logic [DW-1:0] rs1_data_o;
  logic [DW-1:0] rs2_data_o;
  logic [AW-1:0] rd_addr_o;
  logic          illegal_o;

  always #5 clk = ~clk;

  instr_decode_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .arst_ni       (arst_ni),
    .flush_i       (flush_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .rf_rs1_addr_o (rf_rs1_addr_o),
    .rf_rs2_addr_o (rf_rs2_addr_o),
    .rf_rd_en_o    (rf_rd_en_o),
    .rf_rs1_data_i (rf_rs1_data_i),
    .rf_rs2_data_i (rf_rs2_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .op_o          (op_o),
    .use_imm_o     (use_imm_o),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .rd_addr_o     (rd_addr_o),
    .illegal_o     (illegal_o)
  );

  typedef struct {
    logic        illegal;
    logic [3:0]  op;
    logic        use_imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] x_rs1;
    logic [31:0] x_rs2;
    exp_t        e;
  } vec_t;

  typedef struct {
    exp_t e;
    int   due;
  } item_t;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic [31:0] rf_mem [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file model: answers a strobe with data on the following cycle, garbage otherwise.
  task automatic tick();
    logic       en;
    logic [4:0] a1;
    logic [4:0] a2;
    en = rf_rd_en_o;
    a1 = rf_rs1_addr_o;
    a2 = rf_rs2_addr_o;
    @(posedge clk);
    #1;
    cyc++;
    if (en) begin
      rf_rs1_data_i = rf_mem[a1];
      rf_rs2_data_i = rf_mem[a2];
    end else begin
      rf_rs1_data_i = $urandom;
      rf_rs2_data_i = $urandom;
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t       r;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       legal;
    int         simm;
    f7        = w[31:25];
    f3        = w[14:12];
    legal     = 1'b0;
    r.illegal = 1'b1;
    r.op      = 4'd0;
    r.use_imm = 1'b0;
    r.rs1     = 32'd0;
    r.rs2     = 32'd0;
    r.rd      = 5'd0;
    if (w[6:0] == OPC_OP) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (legal) begin
        r.op  = {f7[5], f3};
        r.rs2 = rf_mem[w[24:20]];
      end
    end else if (w[6:0] == OPC_OP_IMM) begin
      r.use_imm = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        r.op  = (f3 == 3'd5) ? {w[30], 3'b101} : 4'b0001;
        r.rs2 = 32'(w[24:20]);
      end else begin
        legal = 1'b1;
        r.op  = {1'b0, f3};
        simm  = int'($signed(w[31:20]));
        r.rs2 = simm;
      end
    end
    if (legal) begin
      r.illegal = 1'b0;
      r.rs1     = rf_mem[w[19:15]];
      r.rd      = w[11:7];
    end else begin
      r.op      = 4'd0;
      r.use_imm = 1'b0;
      r.rs2     = 32'd0;
    end
    return r;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] instr, input logic [31:0] xa, input logic [31:0] xb,
                                  input logic ill, input logic [3:0] op, input logic imm,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    vec_t v;
    v.instr     = instr;
    v.x_rs1     = xa;
    v.x_rs2     = xb;
    v.e.illegal = ill;
    v.e.op      = op;
    v.e.use_imm = imm;
    v.e.rs1     = a;
    v.e.rs2     = b;
    v.e.rd      = rd;
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 5);
    if (sel <= 1 || sel == 5) w[6:0] = OPC_OP;
    else if (sel <= 3)        w[6:0] = OPC_OP_IMM;
    if (sel <= 3) begin
      case ($urandom_range(0, 3))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        default: ;
      endcase
    end
    if (sel == 5) w[31:25] = 7'h00;
    return w;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".ex_valid"}, ex_valid_o, 1);
    check({tag, ".illegal"},  illegal_o,  e.illegal);
    check({tag, ".op"},       op_o,       e.op);
    check({tag, ".use_imm"},  use_imm_o,  e.use_imm);
    check({tag, ".rs1"},      rs1_data_o, e.rs1);
    check({tag, ".rs2"},      rs2_data_o, e.rs2);
    check({tag, ".rd"},       rd_addr_o,  e.rd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t  vecs [9];
  item_t q [$];

  initial begin
    vecs[0] = mk_vec(32'h002081B3, 32'd5,        32'd7,      1'b0, 4'b0000, 1'b0, 32'd5,        32'd7,        5'd3);
    vecs[1] = mk_vec(32'h40335293, 32'h80000000, 32'h1234,   1'b0, 4'b1101, 1'b1, 32'h80000000, 32'd3,        5'd5);
    vecs[2] = mk_vec(32'hFFF00093, 32'd0,        32'hABCD,   1'b0, 4'b0000, 1'b1, 32'd0,        32'hFFFFFFFF, 5'd1);
    vecs[3] = mk_vec(32'h0000006F, 32'd0,        32'd0,      1'b1, 4'b0000, 1'b0, 32'd0,        32'd0,        5'd0);
    vecs[4] = mk_vec(32'h40001013, 32'd0,        32'd0,      1'b1, 4'b0000, 1'b0, 32'd0,        32'd0,        5'd0);
    vecs[5] = mk_vec(32'h40208233, 32'd100,      32'd30,     1'b0, 4'b1000, 1'b0, 32'd100,      32'd30,       5'd4);
    vecs[6] = mk_vec(32'h40209233, 32'd11,       32'd22,     1'b1, 4'b0000, 1'b0, 32'd0,        32'd0,        5'd0);
    vecs[7] = mk_vec(32'h00309093, 32'h000000F0, 32'h5555,   1'b0, 4'b0001, 1'b1, 32'h000000F0, 32'd3,        5'd1);
    vecs[8] = mk_vec(32'h7FF43393, 32'd9,        32'h77,     1'b0, 4'b0011, 1'b1, 32'd9,        32'h7FF,      5'd7);

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    arst_ni       = 1'b0;
    flush_i       = 1'b0;
    instr_i       = 32'd0;
    instr_valid_i = 1'b1;
    ex_ready_i    = 1'b1;
    rf_rs1_data_i = 32'd0;
    rf_rs2_data_i = 32'd0;

    // Reset state.
    #2;
    check("rst.ready",    instr_ready_o, 0);
    check("rst.rd_en",    rf_rd_en_o,    0);
    check("rst.ex_valid", ex_valid_o,    0);
    check("rst.op",       op_o,          0);
    check("rst.rs1",      rs1_data_o,    0);
    check("rst.rs2",      rs2_data_o,    0);
    check("rst.rd",       rd_addr_o,     0);
    check("rst.illegal",  illegal_o,     0);
    check("rst.use_imm",  use_imm_o,     0);
    instr_valid_i = 1'b0;
    tick();
    tick();
    arst_ni = 1'b1;
    #1;
    check("rst.ready_after", instr_ready_o, 1);

    // Table-driven single-instruction vectors.
    for (int i = 0; i < 9; i++) begin
      rf_mem[vecs[i].instr[19:15]] = vecs[i].x_rs1;
      rf_mem[vecs[i].instr[24:20]] = vecs[i].x_rs2;
      instr_i       = vecs[i].instr;
      instr_valid_i = 1'b1;
      ex_ready_i    = 1'b1;
      #1;
      check($sformatf("v%0d.ready", i),    instr_ready_o, 1);
      check($sformatf("v%0d.rd_en", i),    rf_rd_en_o,    1);
      check($sformatf("v%0d.rs1_addr", i), rf_rs1_addr_o, vecs[i].instr[19:15]);
      check($sformatf("v%0d.rs2_addr", i), rf_rs2_addr_o, vecs[i].instr[24:20]);
      tick();
      instr_valid_i = 1'b0;
      #1;
      check($sformatf("v%0d.t1_valid", i), ex_valid_o, 0);
      tick();
      #1;
      check_out($sformatf("v%0d", i), vecs[i].e);
      tick();
      #1;
      check($sformatf("v%0d.t3_valid", i), ex_valid_o, 0);
    end

    // Backpressure: five stalled cycles, then one transfer and a same-cycle acceptance.
    rf_mem[0]     = 32'd0;
    rf_mem[1]     = 32'd5;
    rf_mem[2]     = 32'd7;
    instr_i       = 32'h002081B3;
    instr_valid_i = 1'b1;
    ex_ready_i    = 1'b0;
    #1;
    check("bp.acc", rf_rd_en_o, 1);
    tick();
    instr_i = 32'hFFF00093;
    #1;
    check("bp.s1_ready", instr_ready_o, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check_out($sformatf("bp.hold%0d", k), vecs[0].e);
      check($sformatf("bp.hold%0d.ready", k), instr_ready_o, 0);
      check($sformatf("bp.hold%0d.rd_en", k), rf_rd_en_o,    0);
      tick();
    end
    ex_ready_i = 1'b1;
    #1;
    check("bp.release.ready", instr_ready_o, 1);
    check("bp.release.rd_en", rf_rd_en_o,    1);
    check("bp.release.valid", ex_valid_o,    1);
    tick();
    instr_valid_i = 1'b0;
    #1;
    check("bp.one_transfer", ex_valid_o, 0);
    tick();
    #1;
    check_out("bp.next", vecs[2].e);
    tick();

    // Flush the cycle after acceptance: nothing reaches the ALU.
    instr_i       = 32'h002081B3;
    instr_valid_i = 1'b1;
    #1;
    check("fl.acc", rf_rd_en_o, 1);
    tick();
    flush_i = 1'b1;
    #1;
    check("fl.ready", instr_ready_o, 0);
    check("fl.rd_en", rf_rd_en_o,    0);
    tick();
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    #1;
    check("fl.t2_valid", ex_valid_o, 0);
    tick();
    #1;
    check("fl.t3_valid", ex_valid_o, 0);

    // Flush while idle with an instruction offered: it is not accepted.
    flush_i       = 1'b1;
    instr_valid_i = 1'b1;
    #1;
    check("fli.ready", instr_ready_o, 0);
    check("fli.rd_en", rf_rd_en_o,    0);
    tick();
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    tick();
    #1;
    check("fli.valid", ex_valid_o, 0);

    // Reset while ex_valid_o is held high.
    instr_i       = 32'h002081B3;
    instr_valid_i = 1'b1;
    ex_ready_i    = 1'b0;
    tick();
    instr_valid_i = 1'b0;
    tick();
    #1;
    check("ar.pre_valid", ex_valid_o, 1);
    instr_valid_i = 1'b1;
    #1;
    arst_ni = 1'b0;
    #1;
    check("ar.valid",   ex_valid_o,    0);
    check("ar.rs1",     rs1_data_o,    0);
    check("ar.rd",      rd_addr_o,     0);
    check("ar.ready",   instr_ready_o, 0);
    check("ar.rd_en",   rf_rd_en_o,    0);
    tick();
    arst_ni       = 1'b1;
    instr_valid_i = 1'b0;
    ex_ready_i    = 1'b1;
    #1;
    check("ar.ready_after", instr_ready_o, 1);

    // Reset while S1 is occupied: the instruction is discarded.
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
    #2;
    arst_ni = 1'b0;
    #1;
    check("ar1.rd_en", rf_rd_en_o, 0);
    tick();
    arst_ni = 1'b1;
    #1;
    check("ar1.t_valid", ex_valid_o, 0);
    tick();
    #1;
    check("ar1.t2_valid", ex_valid_o, 0);
    tick();

    // Random traffic against the queue model.
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'd0;
    q.delete();
    for (int i = 0; i < 800; i++) begin
      logic  s1_busy;
      logic  out_vis;
      logic  exp_ready;
      logic  acc;
      item_t it;
      instr_valid_i = ($urandom_range(0, 3) != 0);
      ex_ready_i    = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 19) == 0);
      instr_i       = rand_instr();
      #1;
      s1_busy   = (q.size() > 0) && (q[q.size()-1].due == cyc + 1);
      out_vis   = (q.size() > 0) && (q[0].due <= cyc);
      exp_ready = !flush_i && !s1_busy && (!out_vis || ex_ready_i);
      acc       = exp_ready && instr_valid_i;
      check("rnd.ready",    instr_ready_o, exp_ready);
      check("rnd.rd_en",    rf_rd_en_o,    acc);
      check("rnd.ex_valid", ex_valid_o,    out_vis);
      if (out_vis) check_out("rnd", q[0].e);
      if (acc) begin
        check("rnd.rs1_addr", rf_rs1_addr_o, instr_i[19:15]);
        check("rnd.rs2_addr", rf_rs2_addr_o, instr_i[24:20]);
      end
      if (flush_i) begin
        q.delete();
      end else begin
        if (out_vis && ex_ready_i) void'(q.pop_front());
        if (acc) begin
          it.e   = ref_decode(instr_i);
          it.due = cyc + 2;
          q.push_back(it);
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 (simple_processor_pkg::DATA_WIDTH), the operand and immediate width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, the register-file address width.
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low, arst_ni.
REQ-004 SHALL have the ports below (name direction width meaning):
- clk  in  1  clock
- arst_ni  in  1  async active-low reset
- flush_i  in  1  sync flush of all in-flight state
- instr_i  in  32  RV32I instruction word
- instr_valid_i  in  1  instruction present
- instr_ready_o  out  1  instruction accepted when high with valid
- rf_rs1_addr_o  out  REG_ADDR_WIDTH  register-file read address A
- rf_rs2_addr_o  out  REG_ADDR_WIDTH  register-file read address B
- rf_rd_en_o  out  1  read strobe; data returns next cycle
- rf_rs1_data_i  in  DATA_WIDTH  read data A, valid the cycle after strobe
- rf_rs2_data_i  in  DATA_WIDTH  read data B, valid the cycle after strobe
- ex_valid_o  out  1  decoded operation valid to ALU
- ex_ready_i  in  1  ALU accepts operation
- op_o  out  4  {alt, funct3} ALU operation code
- use_imm_o  out  1  operand 2 is an immediate
- rs1_data_o  out  DATA_WIDTH  operand 1
- rs2_data_o  out  DATA_WIDTH  operand 2 (register or immediate)
- rd_addr_o  out  REG_ADDR_WIDTH  destination register
- illegal_o  out  1  instruction not a supported ALU op

Function
REQ-005 SHALL decode opcode 0110011 (OP) and 0010011 (OP-IMM) only; every other opcode is illegal.
REQ-006 OP: SHALL be legal only for funct7=0000000 (any funct3) or funct7=0100000 with funct3 000 or 101; op_o={funct7[5],funct3}; use_imm_o=0.
REQ-007 OP-IMM: op_o={0,funct3}, except funct3=101, where op_o={instr[30],101}; use_imm_o=1.
REQ-008 OP-IMM shifts (funct3 001/101): SHALL be legal only when instr[31:25] is 0000000, or 0100000 for funct3=101; operand 2 is instr[24:20], zero-extended.
REQ-009 Other OP-IMM: operand 2 SHALL be instr[31:20], sign-extended to DATA_WIDTH.
REQ-010 Illegal instructions SHALL still flow through the pipeline with illegal_o=1, op_o=0000, rd_addr_o=0, and operands 0.
REQ-011 Pipeline:
- S1 holds the decoded fields for exactly one cycle while register-file data returns.
- The OUT register holds the ex_* outputs.
REQ-012 instr_ready_o SHALL equal !flush_i && !s1_valid && (!ex_valid_o || ex_ready_i).
REQ-013 On acceptance, SHALL drive rf_rd_en_o=1 in the same cycle, with rf_rs1_addr_o=instr[19:15] and rf_rs2_addr_o=instr[24:20], combinationally from instr_i.
REQ-014 S1 SHALL transfer unconditionally to OUT on the next edge, capturing rf data then; REQ-012 guarantees OUT is free.
REQ-015 Latency: handshake in cycle T SHALL give ex_valid_o=1 in cycle T+2; maximum throughput is one instruction per two cycles.
REQ-016 When ex_valid_o=1 and ex_ready_i=0, SHALL hold all ex_* outputs stable.
REQ-017 ex_valid_o SHALL clear after an ex handshake unless S1 refills OUT on the same edge.
REQ-018 flush_i=1 SHALL clear s1_valid and ex_valid_o on the next edge; an instruction presented in the same cycle is not accepted.
REQ-019 rf_rd_en_o SHALL be 0 whenever no acceptance occurs.

Reset
REQ-020 With arst_ni low, SHALL immediately force ex_valid_o=0, s1_valid=0, op_o=0, use_imm_o=0, rs1_data_o=0, rs2_data_o=0, rd_addr_o=0, illegal_o=0.
REQ-021 instr_ready_o SHALL be 0 while reset is asserted and 1 on the first cycle after deassertion.
REQ-022 Reset mid-operation SHALL discard S1 and OUT contents and issue no further rf reads.

Verification
REQ-023 ADD: 0x002081B3, x1=5, x2=7 -> cycle T+2: ex_valid_o=1, op_o=0000, use_imm_o=0, rs1_data_o=5, rs2_data_o=7, rd_addr_o=3, illegal_o=0.
REQ-024 SRAI: 0x40335293, x6=0x80000000 -> op_o=1101, use_imm_o=1, rs2_data_o=3, rd_addr_o=5, rs1_data_o=0x80000000.
REQ-025 ADDI: 0xFFF00093 -> op_o=0000, rs2_data_o=0xFFFFFFFF, rd_addr_o=1.
REQ-026 Backpressure:
- Hold ex_ready_i=0 for 5 cycles with a valid output.
- Outputs stay stable; instr_ready_o=0; rf_rd_en_o=0.
- On ex_ready_i=1, exactly one transfer occurs and the next instruction is accepted that cycle.
REQ-027 Illegal and SLLI checks:
- 0x0000006F (JAL) -> illegal_o=1, op_o=0000, rd_addr_o=0.
- 0x40001013 (SLLI with funct7=0100000) -> illegal_o=1.
REQ-028 Flush and reset:
- flush_i pulsed the cycle after acceptance -> no ex_valid_o.
- arst_ni low while ex_valid_o=1 -> ex_valid_o=0 immediately.
